// File: rtl/accel_pkg.sv
// Shared definitions for the host loader: default sizes, command encodings,
// header field positions and the loader FSM state type.
package accel_pkg;

  // Default geometry of the accelerator memories
  localparam int DEF_NUM_SIZE         = 16;
  localparam int DEF_NUM_INSTRUCTIONS = 16;
  localparam int DEF_WORDS_IN_MEMORY  = 32;

  // Header word field positions and widths
  localparam int HDR_CMD_LSB   = 28;
  localparam int HDR_BASE_LSB  = 8;
  localparam int HDR_COUNT_LSB = 0;
  localparam int CMD_W         = 4;
  localparam int BASE_W        = 5;
  localparam int COUNT_W       = 6;

  // Host command encodings
  localparam logic [CMD_W-1:0] CMD_LOAD_INSTR = 4'd1;
  localparam logic [CMD_W-1:0] CMD_LOAD_DATA  = 4'd2;
  localparam logic [CMD_W-1:0] CMD_READBACK   = 4'd3;
  localparam logic [CMD_W-1:0] CMD_RUN        = 4'd4;

  // Decoded header fields
  typedef struct packed {
    logic [CMD_W-1:0]   cmd;
    logic [BASE_W-1:0]  base;
    logic [COUNT_W-1:0] count;
  } header_t;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_INSTR = 3'd1,
    ST_LOAD_DATA  = 3'd2,
    ST_READBACK   = 3'd3,
    ST_RUN_WAIT   = 3'd4
  } state_t;

endpackage

// File: rtl/host_loader.sv
// Host loader: takes a stream of header/payload words from the host and turns
// them into instruction-store writes, data-memory writes, data-memory
// readback, or an accelerator run request.
module host_loader
  import accel_pkg::*;
#(
  parameter int NUM_SIZE         = DEF_NUM_SIZE,
  parameter int NUM_INSTRUCTIONS = DEF_NUM_INSTRUCTIONS,
  parameter int WORDS_IN_MEMORY  = DEF_WORDS_IN_MEMORY
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [31:0]                         in_data,
  output logic                                instr_we,
  output logic [$clog2(NUM_INSTRUCTIONS)-1:0] instr_addr,
  output logic [31:0]                         instr_wdata,
  output logic                                mem_we,
  output logic [$clog2(WORDS_IN_MEMORY)-1:0]  mem_addr,
  output logic [NUM_SIZE-1:0]                 mem_wdata,
  input  logic [NUM_SIZE-1:0]                 mem_rdata,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_SIZE-1:0]                 out_data,
  output logic                                run_start,
  input  logic                                acc_halted,
  output logic                                busy,
  output logic                                cmd_err
);

  localparam int IA = $clog2(NUM_INSTRUCTIONS);
  localparam int MA = $clog2(WORDS_IN_MEMORY);

  state_t               state_reg;
  logic                 instr_we_reg;
  logic [IA-1:0]        instr_addr_reg;
  logic [31:0]          instr_wdata_reg;
  logic                 mem_we_reg;
  logic [MA-1:0]        mem_addr_reg;
  logic [NUM_SIZE-1:0]  mem_wdata_reg;
  logic                 out_valid_reg;
  logic [NUM_SIZE-1:0]  out_data_reg;
  logic                 run_start_reg;
  logic                 cmd_err_reg;

  // Write pointers for the next payload word, already wrapped to the depth
  logic [IA-1:0]        iptr_reg;
  logic [MA-1:0]        mptr_reg;
  // Words still to accept (loads) or still to hand to the host (readback)
  logic [COUNT_W-1:0]   cnt_reg;
  // Readback words not yet fetched into the output register
  logic [COUNT_W-1:0]   rd_left_reg;

  header_t hdr;
  logic    accept;
  logic    rb_xfer;
  logic    rb_load;

  assign hdr = {in_data[HDR_CMD_LSB +: CMD_W],
                in_data[HDR_BASE_LSB +: BASE_W],
                in_data[HDR_COUNT_LSB +: COUNT_W]};

  // The host may push words only while we are idle or collecting payload;
  // held low during reset so nothing is taken while the block is cleared.
  assign in_ready = !rst && ((state_reg == ST_IDLE) ||
                             (state_reg == ST_LOAD_INSTR) ||
                             (state_reg == ST_LOAD_DATA));
  assign accept   = in_valid && in_ready;

  // Readback handshake: a word leaves when the host takes it, and the output
  // register is refilled whenever it is empty or being emptied this cycle.
  assign rb_xfer = out_valid_reg && out_ready;
  assign rb_load = (rd_left_reg != '0) && (!out_valid_reg || out_ready);

  function automatic logic [IA-1:0] instr_next(input logic [IA-1:0] a);
    return (a == IA'(NUM_INSTRUCTIONS - 1)) ? '0 : a + IA'(1);
  endfunction

  function automatic logic [MA-1:0] mem_next(input logic [MA-1:0] a);
    return (a == MA'(WORDS_IN_MEMORY - 1)) ? '0 : a + MA'(1);
  endfunction

  // Loader FSM with all outputs registered; strobes default low each cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      instr_we_reg    <= 1'b0;
      instr_addr_reg  <= '0;
      instr_wdata_reg <= '0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      run_start_reg   <= 1'b0;
      cmd_err_reg     <= 1'b0;
      iptr_reg        <= '0;
      mptr_reg        <= '0;
      cnt_reg         <= '0;
      rd_left_reg     <= '0;
    end else begin
      instr_we_reg  <= 1'b0;
      mem_we_reg    <= 1'b0;
      run_start_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            case (hdr.cmd)
              CMD_LOAD_INSTR: begin
                iptr_reg <= IA'(32'(hdr.base) % NUM_INSTRUCTIONS);
                cnt_reg  <= hdr.count;
                if (hdr.count != '0) state_reg <= ST_LOAD_INSTR;
              end
              CMD_LOAD_DATA: begin
                mptr_reg <= MA'(32'(hdr.base) % WORDS_IN_MEMORY);
                cnt_reg  <= hdr.count;
                if (hdr.count != '0) state_reg <= ST_LOAD_DATA;
              end
              CMD_READBACK: begin
                mem_addr_reg <= MA'(32'(hdr.base) % WORDS_IN_MEMORY);
                cnt_reg      <= hdr.count;
                rd_left_reg  <= hdr.count;
                if (hdr.count != '0) state_reg <= ST_READBACK;
              end
              CMD_RUN: begin
                run_start_reg <= 1'b1;
                state_reg     <= ST_RUN_WAIT;
              end
              default: cmd_err_reg <= 1'b1;
            endcase
          end
        end

        ST_LOAD_INSTR: begin
          if (accept) begin
            instr_we_reg    <= 1'b1;
            instr_addr_reg  <= iptr_reg;
            instr_wdata_reg <= in_data;
            iptr_reg        <= instr_next(iptr_reg);
            cnt_reg         <= cnt_reg - COUNT_W'(1);
            if (cnt_reg == COUNT_W'(1)) state_reg <= ST_IDLE;
          end
        end

        ST_LOAD_DATA: begin
          if (accept) begin
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= mptr_reg;
            mem_wdata_reg <= in_data[NUM_SIZE-1:0];
            mptr_reg      <= mem_next(mptr_reg);
            cnt_reg       <= cnt_reg - COUNT_W'(1);
            if (cnt_reg == COUNT_W'(1)) state_reg <= ST_IDLE;
          end
        end

        ST_READBACK: begin
          if (rb_load) begin
            out_data_reg  <= mem_rdata;
            out_valid_reg <= 1'b1;
            mem_addr_reg  <= mem_next(mem_addr_reg);
            rd_left_reg   <= rd_left_reg - COUNT_W'(1);
          end else if (rb_xfer) begin
            out_valid_reg <= 1'b0;
          end
          if (rb_xfer) begin
            cnt_reg <= cnt_reg - COUNT_W'(1);
            if (cnt_reg == COUNT_W'(1)) begin
              out_valid_reg <= 1'b0;
              state_reg     <= ST_IDLE;
            end
          end
        end

        ST_RUN_WAIT: begin
          if (acc_halted) state_reg <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign instr_we    = instr_we_reg;
  assign instr_addr  = instr_addr_reg;
  assign instr_wdata = instr_wdata_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign run_start   = run_start_reg;
  assign cmd_err     = cmd_err_reg;
  assign busy        = (state_reg != ST_IDLE) || instr_we_reg || mem_we_reg;

endmodule

// File: tb/tb_host_loader.sv
// Testbench for host_loader: drives host commands with random payloads and
// gaps, and checks writes, readback and run handshakes against a simple model.
module tb_host_loader;

  localparam int NS = 16;
  localparam int NI = 16;
  localparam int NW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        instr_we;
  logic [3:0]  instr_addr;
  logic [31:0] instr_wdata;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        run_start;
  logic        acc_halted;
  logic        busy;
  logic        cmd_err;

  host_loader #(.NUM_SIZE(NS), .NUM_INSTRUCTIONS(NI), .WORDS_IN_MEMORY(NW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .instr_we(instr_we), .instr_addr(instr_addr), .instr_wdata(instr_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .run_start(run_start), .acc_halted(acc_halted), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Data memory seen by the DUT, plus a preload port owned by the bench
  logic [15:0] tb_mem [NW];
  logic [15:0] ref_mem [NW];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  assign mem_rdata = tb_mem[mem_addr];

  always @(posedge clk) begin
    if (pre_we) tb_mem[pre_addr] <= pre_data;
    else if (mem_we) tb_mem[mem_addr] <= mem_wdata;
  end

  // Monitor: log every write strobe and run pulse, flag forbidden overlaps
  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t iq[$];
  wr_t mq[$];
  int  rs_count = 0;
  int  viol = 0;

  always @(negedge clk) begin
    if (instr_we) iq.push_back('{int'(instr_addr), instr_wdata});
    if (mem_we) mq.push_back('{int'(mem_addr), 32'(mem_wdata)});
    if (run_start) rs_count++;
    if ((instr_we && mem_we) || (run_start && (instr_we || mem_we))) viol++;
  end

  logic [31:0] payload [64];

  function automatic logic [31:0] make_hdr(input int cmd, input int base, input int count);
    return {4'(cmd), 15'($urandom), 5'(base), 2'($urandom), 6'(count)};
  endfunction

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_word timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drive_load(input int cmd, input int base, input int count);
    send_word(make_hdr(cmd, base, count));
    for (int k = 0; k < count; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send_word(payload[k]);
    end
    idle(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; acc_halted = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    n_cmp++; if ({instr_we, mem_we, out_valid, run_start, busy, cmd_err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000", {instr_we, mem_we, out_valid, run_start, busy, cmd_err});
    end
    n_cmp++; if ({instr_addr, instr_wdata, mem_addr, mem_wdata, out_data} !== '0) begin
      n_bad++; $display("FAIL reset_buses: ia=%h iw=%h ma=%h mw=%h od=%h want 0", instr_addr, instr_wdata, mem_addr, mem_wdata, out_data);
    end
    for (int i = 0; i < NW; i++) begin
      ref_mem[i] = (i >= 8 && i <= 11) ? 16'(i - 3) : 16'($urandom);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 5'(i); pre_data = ref_mem[i];
    end
    @(negedge clk);
    pre_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
    $display("reset done, memory preloaded");
  endtask

  task automatic test_load_instr(input int n_random);
    int base, count, i0;
    for (int t = 0; t <= n_random; t++) begin
      base  = (t == 0) ? 0 : int'($urandom_range(0, 31));
      count = (t == 0) ? 3 : int'($urandom_range(1, 40));
      for (int k = 0; k < count; k++) payload[k] = $urandom;
      i0 = iq.size();
      drive_load(1, base, count);
      $display("load_instr base=%0d count=%0d writes=%0d", base, count, iq.size() - i0);
      n_cmp++; if (iq.size() - i0 != count) begin
        n_bad++; $display("FAIL load_instr_count: got %0d want %0d", iq.size() - i0, count);
      end
      for (int k = 0; k < count && i0 + k < iq.size(); k++) begin
        n_cmp++;
        if (iq[i0 + k].addr != (base + k) % NI || iq[i0 + k].data !== payload[k]) begin
          n_bad++;
          $display("FAIL load_instr_word%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   k, iq[i0 + k].addr, iq[i0 + k].data, (base + k) % NI, payload[k]);
        end
      end
      n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++; $display("FAIL load_instr_idle: busy=%0b in_ready=%0b want 0/1", busy, in_ready);
      end
    end
  endtask

  task automatic test_load_data(input bit fixed, input int n_random);
    int base, count, i0;
    for (int t = 0; t < n_random + (fixed ? 1 : 0); t++) begin
      if (fixed && t == 0) begin
        base = 30; count = 4;
        for (int k = 0; k < count; k++) payload[k] = {16'($urandom), 16'(k + 1)};
      end else begin
        base = int'($urandom_range(0, 31)); count = int'($urandom_range(1, 40));
        for (int k = 0; k < count; k++) payload[k] = $urandom;
      end
      for (int k = 0; k < count; k++) ref_mem[(base + k) % NW] = payload[k][15:0];
      i0 = mq.size();
      drive_load(2, base, count);
      $display("load_data base=%0d count=%0d writes=%0d", base, count, mq.size() - i0);
      n_cmp++; if (mq.size() - i0 != count) begin
        n_bad++; $display("FAIL load_data_count: got %0d want %0d", mq.size() - i0, count);
      end
      for (int k = 0; k < count && i0 + k < mq.size(); k++) begin
        n_cmp++;
        if (mq[i0 + k].addr != (base + k) % NW || mq[i0 + k].data !== {16'h0, payload[k][15:0]}) begin
          n_bad++;
          $display("FAIL load_data_word%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   k, mq[i0 + k].addr, mq[i0 + k].data, (base + k) % NW, payload[k][15:0]);
        end
      end
    end
  endtask

  task automatic test_readback(input bit fixed, input int n_random);
    int base, count, got, cyc, ready_hi, i0;
    logic pv, pr;
    logic [15:0] pd;
    logic [4:0] pat;
    pat = 5'b11101;
    for (int t = 0; t < n_random + (fixed ? 1 : 0); t++) begin
      if (fixed && t == 0) begin base = 8; count = 4; end
      else begin base = int'($urandom_range(0, 31)); count = int'($urandom_range(0, 40)); end
      i0 = mq.size();
      got = 0; cyc = 0; ready_hi = 0; pv = 1'b0; pr = 1'b0; pd = '0;
      send_word(make_hdr(3, base, count));
      while (got < count && cyc < 500) begin
        @(negedge clk);
        in_valid = 1'b0;
        if (fixed && t == 0) out_ready = (cyc < 5) ? pat[cyc] : 1'b1;
        else out_ready = 1'($urandom_range(0, 1));
        if (in_ready) ready_hi++;
        if (pv && !pr) begin
          n_cmp++;
          if (out_valid !== 1'b1 || out_data !== pd) begin
            n_bad++; $display("FAIL readback_stall: got v=%0b d=%h want v=1 d=%h", out_valid, out_data, pd);
          end
        end
        if (out_valid && out_ready) begin
          n_cmp++;
          if (out_data !== ref_mem[(base + got) % NW]) begin
            n_bad++; $display("FAIL readback_word%0d: got %h want %h", got, out_data, ref_mem[(base + got) % NW]);
          end
          got++;
        end
        pv = out_valid; pr = out_ready; pd = out_data; cyc++;
      end
      n_cmp++; if (got != count) begin n_bad++; $display("FAIL readback_timeout: got %0d words want %0d", got, count); end
      n_cmp++; if (ready_hi != 0) begin n_bad++; $display("FAIL readback_in_ready: high %0d cycles want 0", ready_hi); end
      ready_hi = 0;
      repeat (3) begin
        @(negedge clk);
        in_valid = 1'b0;
        if (out_valid || busy || !in_ready) ready_hi++;
      end
      n_cmp++; if (ready_hi != 0 || mq.size() != i0) begin
        n_bad++; $display("FAIL readback_end: bad idle cycles %0d writes %0d want 0/0", ready_hi, mq.size() - i0);
      end
      $display("readback base=%0d count=%0d received=%0d", base, count, got);
    end
  endtask

  task automatic test_run(input int n_random);
    int d, i0, lo;
    logic first;
    for (int t = 0; t <= n_random; t++) begin
      d = (t == 0) ? 10 : int'($urandom_range(1, 20));
      i0 = rs_count; lo = 0; first = 1'b0;
      acc_halted = 1'b0;
      send_word(make_hdr(4, int'($urandom_range(0, 31)), int'($urandom_range(0, 63))));
      for (int c = 0; c < d; c++) begin
        @(negedge clk);
        in_valid = 1'b0;
        if (c == 0) first = run_start;
        if (!busy || in_ready) lo++;
        if (c == d - 1) acc_halted = 1'b1;
      end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++; $display("FAIL run_end: busy=%0b in_ready=%0b want 0/1", busy, in_ready);
      end
      acc_halted = 1'b0;
      idle(2);
      n_cmp++; if (first !== 1'b1 || rs_count - i0 != 1) begin
        n_bad++; $display("FAIL run_pulse: first=%0b pulses=%0d want 1/1", first, rs_count - i0);
      end
      n_cmp++; if (lo != 0) begin n_bad++; $display("FAIL run_busy: %0d wait cycles idle-looking want 0", lo); end
      $display("run delay=%0d pulses=%0d", d, rs_count - i0);
    end
  endtask

  task automatic test_bad_cmd();
    int c, i0, m0, r0;
    for (int t = 0; t < 3; t++) begin
      c = (t == 0) ? 7 : int'($urandom_range(5, 16));
      if (c == 16) c = 0;
      i0 = iq.size(); m0 = mq.size(); r0 = rs_count;
      send_word(make_hdr(c, int'($urandom_range(0, 31)), int'($urandom_range(1, 63))));
      idle(3);
      n_cmp++; if (cmd_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++; $display("FAIL bad_cmd%0d: cmd_err=%0b busy=%0b in_ready=%0b want 1/0/1", c, cmd_err, busy, in_ready);
      end
      n_cmp++; if (iq.size() != i0 || mq.size() != m0 || rs_count != r0) begin
        n_bad++; $display("FAIL bad_cmd_strobes: instr=%0d mem=%0d run=%0d want 0", iq.size() - i0, mq.size() - m0, rs_count - r0);
      end
      $display("bad command %0d cmd_err=%0b", c, cmd_err);
    end
    m0 = mq.size();
    send_word(make_hdr(2, int'($urandom_range(0, 31)), 0));
    idle(3);
    n_cmp++; if (mq.size() != m0 || busy !== 1'b0 || cmd_err !== 1'b1) begin
      n_bad++; $display("FAIL load_data_zero: writes=%0d busy=%0b cmd_err=%0b want 0/0/1", mq.size() - m0, busy, cmd_err);
    end
    $display("load_data count=0 writes=%0d", mq.size() - m0);
  endtask

  task automatic test_reset_mid();
    int m0, base;
    base = int'($urandom_range(0, 31));
    for (int k = 0; k < 4; k++) payload[k] = $urandom;
    m0 = mq.size();
    send_word(make_hdr(2, base, 4));
    send_word(payload[0]);
    send_word(payload[1]);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0 || busy !== 1'b0 || cmd_err !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_flags: mem_we=%0b busy=%0b cmd_err=%0b in_ready=%0b want 0/0/0/0", mem_we, busy, cmd_err, in_ready);
    end
    rst = 1'b0;
    idle(6);
    n_cmp++; if (mq.size() - m0 != 2 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid_end: writes=%0d busy=%0b in_ready=%0b want 2/0/1", mq.size() - m0, busy, in_ready);
    end
    for (int k = 0; k < 2; k++) ref_mem[(base + k) % NW] = payload[k][15:0];
    $display("reset mid-load base=%0d writes=%0d", base, mq.size() - m0);
  endtask

  task automatic test_exclusive();
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL strobe_overlap: %0d cycles want 0", viol); end
    $display("strobe overlap cycles=%0d", viol);
  endtask

  initial begin
    test_reset();
    test_load_instr(4);
    test_load_data(1'b1, 0);
    test_readback(1'b1, 0);
    test_load_data(1'b0, 4);
    test_readback(1'b0, 5);
    test_run(2);
    test_bad_cmd();
    test_reset_mid();
    test_readback(1'b0, 2);
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
